qtcore_scan_master: RTL and testbench
=====================================

Name: qtcore_scan_master

Overview:
- Hardware initiator for the qtcore_a1 scan chain. It replaces the bench-side bit-banging with an on-chip engine.
- Accepts a byte stream from a host-side link, shifts it MSB-first into the core scan chain, and returns the bits captured from scan-out as a byte stream.
- Can also enable the processor until halt or until a cycle budget is exhausted.
- Sits between the host bridge and the core's scan_enable / scan_in / scan_out / proc_en / halt pins, inside the top.

Parameters:
- CHAIN_LEN, 168, scan chain length in bits (24 + 18*8); must be a multiple of 8.
- RUN_MIN, 4, minimum processor-enabled cycles before halt_in is honoured.
- CNT_W, 16, width of the run-cycle budget and counter.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command strobe; accepted only in IDLE.
- cmd_run  input  1  0 = XCHG (scan exchange), 1 = RUN.
- cmd_max  input  CNT_W  RUN cycle budget; sampled on accept.
- busy  output  1  high in any state other than IDLE.
- in_data  input  8  byte to shift in; bit 7 goes first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_data  output  8  captured byte; first captured bit is bit 7.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer ready.
- scan_en_out  output  1  core scan enable; the core shifts on every clk_in edge while high.
- scan_bit_out  output  1  bit presented to core scan_in.
- scan_bit_in  input  1  core scan_out (chain tail).
- proc_en_out  output  1  core processor enable.
- halt_in  input  1  core halt flag.
- run_cycles  output  CNT_W  cycles executed by the last RUN; held until the next RUN.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States: IDLE, LOAD, SHIFT, PUSH, GAP, RUN.
- IDLE:
  - cmd_valid with cmd_run=0 -> LOAD; byte counter = CHAIN_LEN/8.
  - cmd_valid with cmd_run=1 -> RUN; budget = cmd_max; run_cycles cleared.
  - cmd_max=0 -> RUN lasts 0 cycles; return to IDLE next cycle.
- LOAD:
  - in_ready=1; scan_en_out=0.
  - On handshake, latch the byte into the tx shift register -> SHIFT; bit counter = 8.
- SHIFT: exactly 8 cycles.
  - scan_en_out=1 (registered).
  - scan_bit_out = tx[7]; tx shifts left each cycle.
  - Each edge samples scan_bit_in into rx LSB, shifting left. The sample is taken at the same edge the core shifts, so it is the pre-shift tail.
  - After 8 -> PUSH.
- PUSH:
  - scan_en_out=0; out_valid=1; out_data=rx.
  - On out_ready handshake: decrement byte counter; -> LOAD if nonzero, else GAP.
  - Output stall never shifts the chain; scan_en_out stays low.
- GAP: one cycle with scan_en_out=0 -> IDLE.
- XCHG result:
  - Exactly CHAIN_LEN scan_en_out-high cycles per command.
  - Byte k in becomes chain bits [CHAIN_LEN-1-8k -: 8].
  - Byte k out carries the same positions of the previous chain image.
- RUN:
  - proc_en_out=1 each cycle; counter increments per cycle.
  - Exits when counter==budget, or when counter>=RUN_MIN && halt_in=1. Exit check is made before enabling a further cycle.
  - On exit: proc_en_out=0; run_cycles=counter; -> IDLE.
- cmd_valid outside IDLE is ignored; no queuing.
- Simultaneous in_valid in a non-LOAD state: not accepted.
- Reset mid-operation: immediate return to IDLE, outputs 0; a partially shifted chain is left as-is in the core.
- scan_en_out and proc_en_out are never high together.

Optional Feature:
- Macro SCAN_MASTER_CRC_EN.
- Defined:
  - Adds output crc_out, 8 bits: CRC-8, poly 0x07, init 0x00, MSB-first, over every out_data byte of the current XCHG.
  - Cleared when an XCHG is accepted; stable from GAP onward.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset with all inputs 0 -> every output 0, busy=0; cmd_valid during rst_in high is ignored.
- XCHG of 21 bytes with a model chain, where the image's last byte is 0xF0 (the IO register) and the first three bytes set state=001, PC=1, IR=0xE0, ACC=0x01 -> 168 scan_en_out cycles; model chain equals the image; 21 returned bytes equal the prior model contents.
- Hold out_ready low 10 cycles at byte 5 -> no scan_en_out pulses during the stall; final chain still exact.
- RUN cmd_max=256 with halt_in rising at cycle 37 -> proc_en_out high 37 cycles, run_cycles=37.
- RUN with halt_in=1 from the start and cmd_max=8 -> 4 enabled cycles, run_cycles=4.
- SCAN_MASTER_CRC_EN with returned bytes 0x01,0x02 (rest 0) -> crc_out matches the reference CRC-8; reset asserted mid-SHIFT -> IDLE, scan_en_out=0 within 0 cycles (async).

Source files
------------

// File: rtl/qtcore_scan_master.sv
// Scan-chain initiator for qtcore_a1: byte-wise scan exchange and bounded processor runs.
// Optional CRC-8 over returned bytes when SCAN_MASTER_CRC_EN is defined.
module qtcore_scan_master #(
  parameter int CHAIN_LEN = 168,
  parameter int RUN_MIN   = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cmd_valid,
  input  logic             cmd_run,
  input  logic [CNT_W-1:0] cmd_max,
  output logic             busy,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             scan_en_out,
  output logic             scan_bit_out,
  input  logic             scan_bit_in,
  output logic             proc_en_out,
  input  logic             halt_in,
  output logic [CNT_W-1:0] run_cycles
`ifdef SCAN_MASTER_CRC_EN
  ,
  output logic [7:0]       crc_out
`endif
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BC_W   = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PUSH,
    S_GAP,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic             scan_en_q, scan_en_d;
  logic             proc_en_q, proc_en_d;
  logic             run_done;

`ifdef SCAN_MASTER_CRC_EN
  logic [7:0]       crc_q, crc_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Exit is decided before another enabled cycle is granted.
  assign run_done = (cnt_q == budget_q) ||
                    ((cnt_q >= CNT_W'(RUN_MIN)) && halt_in);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    budget_d     = budget_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
`ifdef SCAN_MASTER_CRC_EN
    crc_d        = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_run) begin
            state_d      = S_RUN;
            budget_d     = cmd_max;
            cnt_d        = '0;
            run_cycles_d = '0;
          end else begin
            state_d    = S_LOAD;
            byte_cnt_d = BC_W'(NBYTES);
`ifdef SCAN_MASTER_CRC_EN
            crc_d      = 8'h00;
`endif
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          tx_d      = in_data;
          bit_cnt_d = 4'd8;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Tail is sampled on the same edge the core shifts: pre-shift value.
        tx_d      = {tx_q[6:0], 1'b0};
        rx_d      = {rx_q[6:0], scan_bit_in};
        bit_cnt_d = bit_cnt_q - 4'd1;
        if (bit_cnt_q == 4'd1) state_d = S_PUSH;
      end
      S_PUSH: begin
        if (out_ready) begin
          byte_cnt_d = byte_cnt_q - BC_W'(1);
`ifdef SCAN_MASTER_CRC_EN
          crc_d      = crc8_byte(crc_q, rx_q);
`endif
          state_d    = (byte_cnt_q == BC_W'(1)) ? S_GAP : S_LOAD;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (run_done) begin
          run_cycles_d = cnt_q;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    scan_en_d = (state_d == S_SHIFT);
    proc_en_d = (state_q == S_RUN) && !run_done;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      budget_q     <= '0;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      scan_en_q    <= 1'b0;
      proc_en_q    <= 1'b0;
`ifdef SCAN_MASTER_CRC_EN
      crc_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      budget_q     <= budget_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
      scan_en_q    <= scan_en_d;
      proc_en_q    <= proc_en_d;
`ifdef SCAN_MASTER_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign in_ready     = (state_q == S_LOAD);
  assign out_valid    = (state_q == S_PUSH);
  assign out_data     = rx_q;
  assign scan_en_out  = scan_en_q;
  assign scan_bit_out = tx_q[7];
  assign proc_en_out  = proc_en_q;
  assign run_cycles   = run_cycles_q;
`ifdef SCAN_MASTER_CRC_EN
  assign crc_out      = crc_q;
`endif

endmodule

// File: tb/tb_qtcore_scan_master.sv
// Bench for qtcore_scan_master: behavioural scan-chain model plus scoreboard of returned bytes.
module tb_qtcore_scan_master;

  localparam int CHAIN_LEN = 168;
  localparam int NB        = CHAIN_LEN / 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cmd_valid, cmd_run;
  logic [15:0] cmd_max;
  logic        busy;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic        scan_en_out, scan_bit_out, scan_bit_in;
  logic        proc_en_out, halt_in;
  logic [15:0] run_cycles;
`ifdef SCAN_MASTER_CRC_EN
  logic [7:0]  crc_out;
`endif

  qtcore_scan_master #(.CHAIN_LEN(CHAIN_LEN), .RUN_MIN(4), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cmd_valid(cmd_valid), .cmd_run(cmd_run), .cmd_max(cmd_max), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .scan_en_out(scan_en_out), .scan_bit_out(scan_bit_out), .scan_bit_in(scan_bit_in),
    .proc_en_out(proc_en_out), .halt_in(halt_in), .run_cycles(run_cycles)
`ifdef SCAN_MASTER_CRC_EN
    , .crc_out(crc_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Core scan chain model: shifts toward the MSB, tail is the MSB.
  logic [CHAIN_LEN-1:0] chain, chain_init;
  logic                 chain_ld = 1'b0;
  always @(posedge clk_in) begin
    if (chain_ld) chain <= chain_init;
    else if (scan_en_out) chain <= {chain[CHAIN_LEN-2:0], scan_bit_out};
  end
  assign scan_bit_in = chain[CHAIN_LEN-1];

  int   en_cnt = 0;
  logic overlap_seen = 1'b0;
  always @(posedge clk_in) begin
    if (scan_en_out) en_cnt <= en_cnt + 1;
    if (scan_en_out && proc_en_out) overlap_seen <= 1'b1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [15:0] run_sb[$];

  task automatic start_cmd(input logic run, input logic [15:0] mx);
    cmd_run   = run;
    cmd_max   = mx;
    cmd_valid = 1'b1;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    cmd_run   = 1'b0;
    cmd_max   = 16'd0;
  endtask

  task automatic do_xchg(input logic [CHAIN_LEN-1:0] img, input int stall_k, input int stall_n,
                         input logic poke);
    int         e0, e1, n;
    logic [7:0] exp;
    e0 = en_cnt;
    for (int k = 0; k < NB; k++) sb.push_back(chain[CHAIN_LEN-1-8*k -: 8]);
    start_cmd(1'b0, 16'd0);
    for (int k = 0; k < NB; k++) begin
      if (poke && k == 3) begin cmd_valid = 1'b1; cmd_run = 1'b1; cmd_max = 16'd50; end
      if (poke && k == 4) begin cmd_valid = 1'b0; cmd_run = 1'b0; cmd_max = 16'd0; end
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk_in); n++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL xchg_in_ready byte %0d: in_ready=%b required 1", k, in_ready);
        sb.delete();
        return;
      end
      in_data  = img[CHAIN_LEN-1-8*k -: 8];
      in_valid = 1'b1;
      @(negedge clk_in);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk_in); n++; end
      if (!out_valid) begin
        checks++; errors++;
        $display("FAIL xchg_out_valid byte %0d: out_valid=%b required 1", k, out_valid);
        sb.delete();
        return;
      end
      if (k == stall_k) begin
        e1       = en_cnt;
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (stall_n) @(negedge clk_in);
        checks++;
        if (en_cnt !== e1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall: scan pulses %0d out_valid=%b in_ready=%b required 0/1/0",
                   en_cnt - e1, out_valid, in_ready);
        end
        in_valid = 1'b0;
      end
      exp = sb.pop_front();
      checks++;
      if (out_data !== exp) begin
        errors++;
        $display("FAIL xchg_out byte %0d: got %h required %h", k, out_data, exp);
      end
      out_ready = 1'b1;
      @(negedge clk_in);
      out_ready = 1'b0;
    end
    n = 0;
    while (busy && n < 20) begin @(negedge clk_in); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL xchg_done: busy=%b required 0", busy);
    end
    checks++;
    if (en_cnt - e0 !== CHAIN_LEN) begin
      errors++;
      $display("FAIL xchg_scan_cycles: got %0d required %0d", en_cnt - e0, CHAIN_LEN);
    end
    checks++;
    if (chain !== img) begin
      errors++;
      $display("FAIL xchg_chain: got %h required %h", chain, img);
    end
  endtask

  function automatic logic [CHAIN_LEN-1:0] rand_img();
    logic [CHAIN_LEN-1:0] v;
    for (int k = 0; k < NB; k++) v[CHAIN_LEN-1-8*k -: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic do_run(input logic [15:0] mx, input int halt_at, input logic halt_start,
                        input logic [15:0] exp_cycles);
    int         hc, n;
    logic [15:0] exp;
    run_sb.push_back(exp_cycles);
    hc = 0;
    halt_in = halt_start;
    start_cmd(1'b1, mx);
    n = 0;
    while (busy && n < 1000) begin
      if (proc_en_out) begin
        hc++;
        if (hc == halt_at) halt_in = 1'b1;
      end
      @(negedge clk_in);
      n++;
    end
    halt_in = 1'b0;
    exp = run_sb.pop_front();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL run_timeout: busy=%b required 0", busy);
    end
    checks++;
    if (hc !== int'(exp)) begin
      errors++;
      $display("FAIL run_enabled_cycles: got %0d required %0d", hc, exp);
    end
    repeat (3) @(negedge clk_in);
    checks++;
    if (run_cycles !== exp || proc_en_out !== 1'b0) begin
      errors++;
      $display("FAIL run_cycles: got %0d proc_en=%b required %0d proc_en=0",
               run_cycles, proc_en_out, exp);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; cmd_valid = 1'b0; cmd_run = 1'b0; cmd_max = 16'd0;
    in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0; halt_in = 1'b0;
    chain_init = {6{$urandom}};
    chain_ld = 1'b1;
    repeat (3) @(negedge clk_in);
    chain_ld = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid, scan_en_out, scan_bit_out, proc_en_out} !== 6'b0 ||
        out_data !== 8'd0 || run_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rdy=%b ov=%b se=%b sb=%b pe=%b od=%h rc=%0d required all 0",
               busy, in_ready, out_valid, scan_en_out, scan_bit_out, proc_en_out, out_data, run_cycles);
    end
    cmd_valid = 1'b1; cmd_run = 1'b1; cmd_max = 16'd5;
    repeat (2) @(negedge clk_in);
    cmd_valid = 1'b0; cmd_run = 1'b0; cmd_max = 16'd0;
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (busy !== 1'b0 || proc_en_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ignored: busy=%b proc_en=%b required 0/0", busy, proc_en_out);
    end
  endtask

  task automatic test_xchg();
    logic [CHAIN_LEN-1:0] img;
    img = rand_img();
    img[CHAIN_LEN-1 -: 24] = {3'b001, 5'd1, 8'hE0, 8'h01};
    img[7:0] = 8'hF0;
    do_xchg(img, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_xchg(rand_img(), -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_xchg(rand_img(), 5, 10, 1'b1);
    checks++;
    if (overlap_seen !== 1'b0) begin
      errors++;
      $display("FAIL scan_proc_overlap: seen=%b required 0", overlap_seen);
    end
  endtask

  task automatic test_run();
    do_run(16'd256, 37, 1'b0, 16'd37);
    do_run(16'd8, 0, 1'b1, 16'd4);
    do_run(16'd10, 0, 1'b0, 16'd10);
    do_run(16'd0, 0, 1'b0, 16'd0);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    start_cmd(1'b0, 16'd0);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk_in); n++; end
    in_data = 8'h5A; in_valid = 1'b1;
    @(negedge clk_in);
    in_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (scan_en_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift_active: scan_en=%b required 1", scan_en_out);
    end
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if (scan_en_out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: se=%b busy=%b rdy=%b ov=%b required 0",
               scan_en_out, busy, in_ready, out_valid);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    do_xchg(rand_img(), -1, 0, 1'b0);
  endtask

`ifdef SCAN_MASTER_CRC_EN
  task automatic test_crc();
    logic [7:0] ref_crc;
    logic       fb;
    chain_init = {8'h01, 8'h02, {(CHAIN_LEN-16){1'b0}}};
    chain_ld = 1'b1;
    @(negedge clk_in);
    chain_ld = 1'b0;
    ref_crc = 8'h00;
    for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
      fb = ref_crc[7] ^ chain_init[i];
      ref_crc = {ref_crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    do_xchg(rand_img(), -1, 0, 1'b0);
    checks++;
    if (crc_out !== ref_crc) begin
      errors++;
      $display("FAIL crc: got %h required %h", crc_out, ref_crc);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_xchg();
    test_back_to_back();
    test_stall();
    test_run();
    test_reset_mid_shift();
`ifdef SCAN_MASTER_CRC_EN
    test_crc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
